// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- bundle of every signal between the fetch stage and its
// neighbours (instruction memory, decode).
//   master : the fetch_unit side (drives request, address, IR, pc, halted)
//   slave  : the environment side (memory ack/data, decode ready/next-PC)
// Widths are fixed at 8 bits, matching the fetch unit's DATA_W.
interface fetch_unit_if;
    // instruction memory request/acknowledge
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    // decode valid/ready and latched instruction fields
    logic       ir_valid;
    logic       ir_ready;
    logic [2:0] ir_op;
    logic [4:0] ir_field;
    logic       ir_last_bit;
    // next-PC decision from decode, sampled on accept
    logic       pc_src;
    logic [7:0] jump_target;
    // status
    logic [7:0] pc;
    logic       halted;

    modport master (
        output imem_req, imem_addr, ir_valid, ir_op, ir_field, ir_last_bit, pc, halted,
        input  imem_ack, imem_data, ir_ready, pc_src, jump_target
    );

    modport slave (
        input  imem_req, imem_addr, ir_valid, ir_op, ir_field, ir_last_bit, pc, halted,
        output imem_ack, imem_data, ir_ready, pc_src, jump_target
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage of the 8-bit processor.
// Holds the PC, fetches one word per request over imem_req/imem_ack, latches
// it into IR and offers it to decode over ir_valid/ir_ready. On accept the
// next PC is PC+1 (pc_src=1) or jump_target (pc_src=0).
// Ports:
//   ck  : clock, rising edge
//   rst : synchronous reset, active-high
//   fu  : fetch_unit_if.master (imem_*, ir_*, pc_src, jump_target, pc, halted)
// Parameters: DATA_W (fixed at 8), RESET_PC (PC after reset).
// Build option: define FETCH_HALT_DETECT_EN to stop fetching after the word
// 8'hFF has been accepted by decode (halted=1 until rst). Without it, 8'hFF is
// an ordinary instruction and halted stays 0.
module fetch_unit #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input logic          ck,
    input logic          rst,
    fetch_unit_if.master fu
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] ir_q;
    logic              req_q;
    logic              valid_q;
    logic              halted_q;

    logic              accept;
    logic              halt_word;
    logic [DATA_W-1:0] next_pc;

    // ir_valid is high exactly while in ISSUE, so the state alone qualifies ready.
    assign accept  = (state == ISSUE) && fu.ir_ready;
    // Modulo-2^DATA_W increment: FF wraps to 00.
    assign next_pc = fu.pc_src ? pc_q + DATA_W'(1) : fu.jump_target;

`ifdef FETCH_HALT_DETECT_EN
    assign halt_word = (ir_q == {DATA_W{1'b1}});
`else
    assign halt_word = 1'b0;
`endif

    always_ff @(posedge ck) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state    <= IDLE;
            pc_q     <= RESET_PC;
            // NOTE: IR is a single register, not a memory, so it is reset too;
            // decode sees 8'h00 rather than X while held in reset.
            ir_q     <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_q <= 1'b1;
                    state <= FETCH;
                end
                FETCH: begin
                    // Request and address (pc_q) stay put until the ack arrives.
                    if (fu.imem_ack) begin
                        ir_q    <= fu.imem_data;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        valid_q <= 1'b0;
                        if (halt_word) begin
                            // pc stays at the halt address.
                            halted_q <= 1'b1;
                            state    <= HALT;
                        end else begin
                            pc_q  <= next_pc;
                            req_q <= 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                HALT: begin
                    // Only rst leaves this state.
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fu.imem_req    = req_q;
    assign fu.imem_addr   = pc_q;
    assign fu.ir_valid    = valid_q;
    assign fu.ir_op       = ir_q[7:5];
    assign fu.ir_field    = ir_q[4:0];
    assign fu.ir_last_bit = ir_q[0];
    assign fu.pc          = pc_q;
    assign fu.halted      = halted_q;

endmodule
